// File: rtl/ram_portb_arbiter_if.sv
// Requester-side bus for RAM port B: one command held with req until a single-cycle done.
// The requester drives the master modport, the arbiter the slave modport.
interface ram_portb_arbiter_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        done;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, be, addr, wdata, input  done, rdata, err);
   modport slave  (input  req, we, be, addr, wdata, output done, rdata, err);
endinterface

// File: rtl/ram_portb_arbiter.sv
// Round-robin arbiter sharing RAM port B between the core and the debug loader.
// Partial stores become read-modify-write; out-of-range and zero-byte-enable stores finish without a RAM access.
module ram_portb_arbiter #(
   parameter int MEM_WORDS = 2048,
   parameter int ADDR_W    = 11
) (
   input  logic                    clk,
   input  logic                    reset,
   ram_portb_arbiter_if.slave      cpu,
   ram_portb_arbiter_if.slave      dbg,
   output logic [31:0]             ram_addr,
   output logic [3:0]              ram_web,
   output logic [31:0]             ram_din,
   input  logic [31:0]             ram_dout,
   output logic                    busy
);

   typedef enum logic [2:0] {IDLE, READ, READ_DATA, WRITE, ERR} state_t;
   typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_t;

   state_t              state, state_nx;
   owner_t              owner, last_grant;
   logic                lat_we;
   logic                lat_err;
   logic [3:0]          lat_be;
   logic [ADDR_W-1:0]   lat_idx;
   logic [31:0]         lat_wdata;
   logic [31:0]         wbuf;
   logic [31:0]         merged;

   logic                grant_valid;
   owner_t              grant_who;
   logic                sel_we;
   logic [3:0]          sel_be;
   logic [31:0]         sel_addr;
   logic [31:0]         sel_wdata;
   logic                sel_oor;

   logic                done_now;
   logic                rd_now;
   logic                err_now;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^{cpu.addr[1:0], dbg.addr[1:0]};

   // Round-robin: on a tie the requester that did not win last time is granted.
   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      grant_valid = cpu.req | dbg.req;
      grant_who   = OWN_CPU;
      if (cpu.req && dbg.req)
         grant_who = (last_grant == OWN_CPU) ? OWN_DBG : OWN_CPU;
      else if (dbg.req)
         grant_who = OWN_DBG;

      sel_we    = cpu.we;
      sel_be    = cpu.be;
      sel_addr  = cpu.addr;
      sel_wdata = cpu.wdata;
      if (grant_who == OWN_DBG) begin
         sel_we    = dbg.we;
         sel_be    = dbg.be;
         sel_addr  = dbg.addr;
         sel_wdata = dbg.wdata;
      end
      sel_oor = (sel_addr[31:2] >= 30'(MEM_WORDS));
   end

   always_comb begin
      merged = '0;
      for (int k = 0; k < 4; k++)
         merged[8*k +: 8] = lat_be[k] ? lat_wdata[8*k +: 8] : ram_dout[8*k +: 8];
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (grant_valid) begin
               if (sel_oor)
                  state_nx = ERR;
               else if (sel_we && sel_be == 4'hF)
                  state_nx = WRITE;
               else if (sel_we && sel_be == 4'h0)
                  state_nx = ERR;
               else
                  state_nx = READ;
            end
         end
         READ:      state_nx = READ_DATA;
         READ_DATA: state_nx = lat_we ? WRITE : IDLE;
         WRITE:     state_nx = IDLE;
         ERR:       state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: this block has a plain synchronous reset; there is no storage array here, so every register is cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= OWN_DBG;
         owner      <= OWN_CPU;
         lat_we     <= 1'b0;
         lat_err    <= 1'b0;
         lat_be     <= '0;
         lat_idx    <= '0;
         lat_wdata  <= '0;
         wbuf       <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && grant_valid) begin
            owner      <= grant_who;
            last_grant <= grant_who;
            lat_we     <= sel_we;
            lat_be     <= sel_be;
            lat_idx    <= sel_addr[ADDR_W+1:2];
            lat_wdata  <= sel_wdata;
            lat_err    <= sel_oor;
            if (!sel_oor && sel_we && sel_be == 4'hF)
               wbuf <= sel_wdata;
         end else if (state == READ_DATA && lat_we) begin
            wbuf <= merged;
         end
      end
   end

   // Completion and RAM write strobe are masked by reset so an aborted transaction leaves no trace.
   assign done_now = !reset && ((state == WRITE) || (state == ERR) ||
                                (state == READ_DATA && !lat_we));
   assign rd_now   = !reset && (state == READ_DATA) && !lat_we;
   assign err_now  = !reset && (state == ERR) && lat_err;

   assign cpu.done  = done_now && (owner == OWN_CPU);
   assign cpu.err   = err_now  && (owner == OWN_CPU);
   assign cpu.rdata = (rd_now && owner == OWN_CPU) ? ram_dout : 32'h0;
   assign dbg.done  = done_now && (owner == OWN_DBG);
   assign dbg.err   = err_now  && (owner == OWN_DBG);
   assign dbg.rdata = (rd_now && owner == OWN_DBG) ? ram_dout : 32'h0;

   assign ram_addr = {{(30-ADDR_W){1'b0}}, lat_idx, 2'b00};
   assign ram_din  = wbuf;
   assign ram_web  = (state == WRITE && !reset) ? 4'hF : 4'h0;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// Self-checking bench for ram_portb_arbiter: a bench-owned port-B RAM, a shadow memory model
// and a scoreboard of expected completions compared whenever a done pulse appears.
module tb_ram_portb_arbiter;
   localparam int MEM_WORDS = 2048;
   localparam bit CPU = 1'b0;
   localparam bit DBG = 1'b1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ram_addr, ram_din, ram_dout;
   logic [3:0]  ram_web;
   logic        busy;

   ram_portb_arbiter_if cpu_if ();
   ram_portb_arbiter_if dbg_if ();

   ram_portb_arbiter #(.MEM_WORDS(MEM_WORDS), .ADDR_W(11)) dut (
      .clk      (clk),
      .reset    (reset),
      .cpu      (cpu_if),
      .dbg      (dbg_if),
      .ram_addr (ram_addr),
      .ram_web  (ram_web),
      .ram_din  (ram_din),
      .ram_dout (ram_dout),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          owner;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          t0;
      logic [3:0]  web;
      logic [31:0] addr;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [31:0] ram    [0:MEM_WORDS-1];
   logic [31:0] shadow [0:MEM_WORDS-1];

   // Port-B RAM: read-first, one-cycle synchronous read latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_web == 4'hF) ram[ram_addr[12:2]] <= ram_din;
      ram_dout <= ram[ram_addr[12:2]];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic drive(input bit who, input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (who == DBG) begin
         dbg_if.req = req; dbg_if.we = we; dbg_if.be = be; dbg_if.addr = addr; dbg_if.wdata = wdata;
      end else begin
         cpu_if.req = req; cpu_if.we = we; cpu_if.be = be; cpu_if.addr = addr; cpu_if.wdata = wdata;
      end
   endtask

   // Computes the expected completion from the shadow model, queues it, and presents the command.
   task automatic issue(input bit who, input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit push, input bit timed);
      exp_t e;
      int   idx = int'(addr[31:2]);
      e.owner = who; e.rdata = '0; e.err = 1'b0; e.lat = 0; e.web = 4'h0;
      e.t0    = timed ? cyc : -1;
      e.addr  = {addr[31:2], 2'b00};
      if (idx >= MEM_WORDS) begin
         e.err = 1'b1; e.lat = 1;
      end else if (we && be == 4'hF) begin
         e.lat = 1; e.web = 4'hF;
         if (push) shadow[idx] = wdata;
      end else if (we && be == 4'h0) begin
         e.lat = 1;
      end else if (we) begin
         e.lat = 3; e.web = 4'hF;
         if (push)
            for (int k = 0; k < 4; k++)
               if (be[k]) shadow[idx][8*k +: 8] = wdata[8*k +: 8];
      end else begin
         e.lat = 2; e.rdata = shadow[idx];
      end
      if (push) sb.push_back(e);
      drive(who, 1'b1, we, be, addr, wdata);
   endtask

   task automatic wait_done(input bit who);
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         seen = (who == DBG) ? dbg_if.done : cpu_if.done;
      end
      if (!seen) check((who == DBG) ? "dbg_timeout" : "cpu_timeout", 32'd0, 32'd1);
   endtask

   task automatic release_req(input bit who);
      @(posedge clk); #1;
      drive(who, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic txn(input bit who, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata);
      @(posedge clk); #1;
      issue(who, we, be, addr, wdata, 1'b1, 1'b1);
      wait_done(who);
      release_req(who);
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin : mon
      exp_t        e;
      logic        who;
      logic [31:0] rd;
      logic        er;
      logic [2:0]  other;
      if (reset) check("web_in_reset", {28'h0, ram_web}, 32'h0);
      if (cpu_if.done && dbg_if.done) begin
         check("double_done", 32'd1, 32'd0);
      end else if (cpu_if.done || dbg_if.done) begin
         who   = dbg_if.done;
         rd    = who ? dbg_if.rdata : cpu_if.rdata;
         er    = who ? dbg_if.err   : cpu_if.err;
         other = who ? {cpu_if.done, cpu_if.err, |cpu_if.rdata}
                     : {dbg_if.done, dbg_if.err, |dbg_if.rdata};
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("owner", {31'h0, who}, {31'h0, e.owner});
            check("rdata", rd, e.rdata);
            check("err", {31'h0, er}, {31'h0, e.err});
            check("other_quiet", {29'h0, other}, 32'h0);
            if (e.t0 >= 0) check("latency", cyc - e.t0, e.lat);
            check("web_at_done", {28'h0, ram_web}, {28'h0, e.web});
            if (e.web == 4'hF) check("addr_at_done", ram_addr, e.addr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0]  b;
      for (int i = 0; i < MEM_WORDS; i++) begin
         ram[i] = 32'h0; shadow[i] = 32'h0;
      end
      ram[16] = 32'hDEADBEEF; shadow[16] = 32'hDEADBEEF;
      ram[32] = 32'h11223344; shadow[32] = 32'h11223344;
      drive(CPU, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(DBG, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_web", {28'h0, ram_web}, 32'h0);
      check("rst_addr", ram_addr, 32'h0);
      check("rst_din", ram_din, 32'h0);
      check("rst_cpu_out", {cpu_if.done, cpu_if.err, cpu_if.rdata[29:0]}, 32'h0);
      check("rst_dbg_out", {dbg_if.done, dbg_if.err, dbg_if.rdata[29:0]}, 32'h0);
      reset = 1'b0;

      // Full store/load, partial store, out-of-range, no-op, top word.
      txn(CPU, 1'b1, 4'hF, 32'h100, 32'hCAFEF00D);
      txn(CPU, 1'b0, 4'h0, 32'h100, 32'h0);
      txn(CPU, 1'b1, 4'b0010, 32'h40, 32'h00001200);
      txn(CPU, 1'b0, 4'h0, 32'h40, 32'h0);
      check("partial_model", shadow[16], 32'hDEAD12EF);
      txn(DBG, 1'b0, 4'h0, 32'h2000, 32'h0);
      txn(CPU, 1'b1, 4'h0, 32'h100, 32'hFFFFFFFF);
      txn(CPU, 1'b0, 4'h0, 32'h100, 32'h0);
      txn(DBG, 1'b1, 4'hF, 32'h1FFC, 32'h0BADCAFE);
      txn(DBG, 1'b0, 4'h0, 32'h1FFC, 32'h0);

      // Reset during READ_DATA of a partial store: dropped, no write, no done.
      @(posedge clk); #1;
      issue(CPU, 1'b1, 4'b0100, 32'h80, 32'h00AA0000, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      drive(CPU, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      check("rmw_rst_busy", {31'h0, busy}, 32'h0);
      check("rmw_rst_word", ram[32], 32'h11223344);
      @(posedge clk); #1;
      reset = 1'b0;

      // Contention straight after reset: cpu first, then dbg, then cpu again.
      @(posedge clk); #1;
      issue(CPU, 1'b0, 4'h0, 32'h100, 32'h0, 1'b1, 1'b0);
      issue(DBG, 1'b1, 4'hF, 32'h200, 32'h5A5A0001, 1'b1, 1'b0);
      wait_done(CPU);
      @(posedge clk); #1;
      issue(CPU, 1'b0, 4'h0, 32'h200, 32'h0, 1'b1, 1'b0);
      wait_done(DBG);
      release_req(DBG);
      wait_done(CPU);
      release_req(CPU);

      txn(CPU, 1'b0, 4'h0, 32'h80, 32'h0);

      // Mixed partial stores and reads from both requesters.
      for (int i = 0; i < 6; i++) begin
         a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         b = 4'($urandom_range(1, 15));
         d = $urandom;
         txn(bit'(i % 2), 1'b1, b, a, d);
         txn(bit'((i + 1) % 2), 1'b0, 4'h0, a, 32'h0);
      end

      repeat (3) @(posedge clk);
      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/ram_portb_arbiter.md
Name: ram_portb_arbiter

Overview:
- Sits between the core's data-memory interface, the debug/program loader and port B of the dual-port RAM.
- Shares that single port between the two requesters and sequences every access.
- Partial stores become read-modify-write: the RAM commits whole words only, so byte enables are merged here.
- Also flags out-of-range addresses.
- Port A (instruction fetch) is untouched.

Parameters:
- MEM_WORDS, 2048: words addressable through port B (the RAM indexes byte address bits [12:2]).
- ADDR_W, 11: word-index width, equal to log2(MEM_WORDS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  core request; held with command until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  4  byte enables for writes; bit k selects byte k
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  write data
- cpu_done  out  1  single-cycle completion pulse
- cpu_rdata  out  32  read word, valid only with cpu_done
- cpu_err  out  1  out-of-range flag, valid only with cpu_done
- dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata, dbg_done, dbg_rdata, dbg_err: same as the cpu_* ports, for the loader
- ram_addr  out  32  to RAM addrB; {word_index, 2'b00}
- ram_web  out  4  to RAM web; 4'hF = write, 0 = read
- ram_din  out  32  to RAM dinB
- ram_dout  in  32  from RAM doutB; one-cycle synchronous read latency
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - state = IDLE, last_grant = dbg, so the cpu wins the first tie.
  - Latched command cleared.
  - All done, err and rdata outputs 0; busy 0; ram_web 0; ram_addr and ram_din 0.
- Reset mid-operation: ram_web is combinationally gated by !reset, so no RAM write occurs in any cycle where reset is high. State returns to IDLE, no done pulse is issued, and the transaction is dropped.
- RAM-side outputs are combinational from registered state: ram_addr from latched addr, ram_din from merge buffer wbuf. ram_web = 4'hF only in WRITE, otherwise 0.
- States: IDLE, READ, READ_DATA, WRITE, ERR.
- IDLE: sample both req lines.
  - Both high: grant the requester that is not last_grant (round-robin).
  - One high: grant it.
  - On grant, latch we, be, word index, wdata and owner, and update last_grant.
  - If addr[31:2] >= MEM_WORDS, go to ERR.
  - Else if we and be == 4'hF: wbuf = wdata, go to WRITE.
  - Else if we and be == 0: go to ERR with err = 0, i.e. a no-op done.
  - Else (read or partial write): go to READ.
- READ: ram_web = 0 with the address driven; the RAM registers doutB at the end of this cycle. Next state READ_DATA.
- READ_DATA: ram_dout is valid.
  - Read: pulse owner done, drive owner rdata = ram_dout, go to IDLE.
  - Partial write: per-byte merge, wbuf[8k+7:8k] = be[k] ? wdata byte k : ram_dout byte k; go to WRITE.
- WRITE: ram_web = 4'hF, ram_din = wbuf. The RAM commits at the closing edge. Pulse owner done in this cycle, then go to IDLE.
- ERR: pulse owner done, with err = 1 for out-of-range and 0 for a zero-be no-op. rdata = 0, no RAM access. Go to IDLE.
- Latency, counted from the IDLE grant cycle as cycle 0:
  - Full write or ERR: done in cycle 1.
  - Read: done in cycle 2.
  - Partial write: done in cycle 3.
  - After every transaction there is one IDLE cycle before the next grant.
- Requester rule: req and command stay stable until done. In the cycle after done, req is either low or carries a new command. req is sampled only in IDLE.
- The non-owner's done, err and rdata stay 0. Only one done pulse is issued per granted request.

Test Plan:
- Full store and load: cpu write addr 0x100, be F, data 0xCAFEF00D → cpu_done in cycle 1 with ram_web F and ram_addr 0x100. Then cpu read 0x100 → cpu_done in cycle 2, cpu_rdata 0xCAFEF00D.
- Partial store: word 0x40 holds 0xDEADBEEF; cpu write be 4'b0010, data 0x00001200 → done in cycle 3; a later read returns 0xDEAD12EF.
- Contention: cpu_req and dbg_req both rise in the same cycle → cpu is granted first (reset last_grant = dbg), dbg next. With both held continuously, grants alternate cpu, dbg, cpu.
- Out of range: dbg read addr 0x2000 (word 2048) → dbg_done with dbg_err = 1 in cycle 1, rdata 0, ram_web 0 throughout.
- No-op: cpu write be 0 → cpu_done in cycle 1 with err 0; the RAM word is unchanged.
- Reset mid-RMW: assert reset during READ_DATA of a partial write → no cycle has ram_web != 0; state is IDLE and busy is 0 after the edge; no done pulse; the target word is unchanged.
